// File: rtl/corr_accum_if.sv
// Sample/dump bus between the correlator input mux, the accumulate-and-dump stage
// and the bus-interface reader.
`ifndef NUM_ACCUM
`define NUM_ACCUM 2
`endif

interface corr_accum_if #(
  parameter int NUM_ACCUM = `NUM_ACCUM,
  parameter int ACC_W     = 16,
  parameter int EPOCH_W   = 16
);
  logic                       enable;
  logic                       sample_en;
  logic [2*NUM_ACCUM-1:0]     signal_re;
  logic [2*NUM_ACCUM-1:0]     signal_im;
  logic                       code_in;
  logic [EPOCH_W-1:0]         epoch_len;
  logic                       dump_ack;
  logic [NUM_ACCUM*ACC_W-1:0] dump_re;
  logic [NUM_ACCUM*ACC_W-1:0] dump_im;
  logic                       dump_valid;
  logic                       dump_sat;
  logic                       ovf;

  modport master (
    output enable, sample_en, signal_re, signal_im, code_in, epoch_len, dump_ack,
    input  dump_re, dump_im, dump_valid, dump_sat, ovf
  );

  modport slave (
    input  enable, sample_en, signal_re, signal_im, code_in, epoch_len, dump_ack,
    output dump_re, dump_im, dump_valid, dump_sat, ovf
  );
endinterface

// File: rtl/corr_accum.sv
// Correlator accumulate-and-dump: code-wipes 2-bit sign-magnitude re/im samples per lane,
// integrates them with saturation over a programmable epoch and dumps to holding registers.
`ifndef NUM_ACCUM
`define NUM_ACCUM 2
`endif

module corr_accum #(
  parameter int NUM_ACCUM = `NUM_ACCUM,
  parameter int ACC_W     = 16,
  parameter int EPOCH_W   = 16
) (
  input logic         pclk,
  input logic         reset,
  corr_accum_if.slave bus
);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]           r_acc_re [NUM_ACCUM];
  logic [ACC_W-1:0]           r_acc_im [NUM_ACCUM];
  logic [ACC_W-1:0]           w_sum_re [NUM_ACCUM];
  logic [ACC_W-1:0]           w_sum_im [NUM_ACCUM];
  logic [NUM_ACCUM-1:0]       w_clip_re;
  logic [NUM_ACCUM-1:0]       w_clip_im;
  logic [EPOCH_W-1:0]         r_count;
  logic [EPOCH_W-1:0]         w_last;
  logic [NUM_ACCUM*ACC_W-1:0] r_hold_re;
  logic [NUM_ACCUM*ACC_W-1:0] r_hold_im;
  logic                       r_sat_flag;
  logic                       r_dump_valid;
  logic                       r_dump_sat;
  logic                       r_ovf;
  logic                       w_accept;
  logic                       w_wrap;
  logic                       w_dump;
  logic                       w_clip_any;

  // Sign-magnitude decode (bit1 sign, bit0 picks 3 over 1), negated when the chip is 1.
  function automatic logic [2:0] wipe(input logic [1:0] s, input logic code);
    logic [2:0] mag;
    mag = s[0] ? 3'd3 : 3'd1;
    return (s[1] ^ code) ? (3'd0 - mag) : mag;
  endfunction

  // Returns {clip, value}: overflow shows up as the two top bits of the widened sum disagreeing.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [2:0] d);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-2){d[2]}}, d};
    if (s[ACC_W] == s[ACC_W-1]) return {1'b0, s[ACC_W-1:0]};
    return {1'b1, s[ACC_W] ? ACC_MIN : ACC_MAX};
  endfunction

  // NOTE: combinational outputs are fully assigned on every pass, so no latches can form.
  always_comb begin
    w_clip_re = '0;
    w_clip_im = '0;
    for (int i = 0; i < NUM_ACCUM; i++) begin
      {w_clip_re[i], w_sum_re[i]} = sat_add(r_acc_re[i], wipe(bus.signal_re[2*i +: 2], bus.code_in));
      {w_clip_im[i], w_sum_im[i]} = sat_add(r_acc_im[i], wipe(bus.signal_im[2*i +: 2], bus.code_in));
    end
  end

  // A lowered epoch_len can leave the counter above L-1; it then runs to all-ones and dumps there.
  assign w_last     = (bus.epoch_len == '0) ? '0 : bus.epoch_len - EPOCH_W'(1);
  assign w_wrap     = &r_count;
  assign w_accept   = bus.enable & bus.sample_en;
  assign w_dump     = w_accept & ((r_count == w_last) | w_wrap);
  assign w_clip_any = |{w_clip_re, w_clip_im};

  // NOTE: state uses non-blocking assignments; where two apply to one register the later one wins,
  // which is how a dump overrides an ack landing on the same edge.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACCUM; i++) begin
        r_acc_re[i] <= '0;
        r_acc_im[i] <= '0;
      end
      r_count      <= '0;
      r_sat_flag   <= 1'b0;
      r_hold_re    <= '0;
      r_hold_im    <= '0;
      r_dump_valid <= 1'b0;
      r_dump_sat   <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (r_dump_valid && bus.dump_ack) r_dump_valid <= 1'b0;
      if (!bus.enable) begin
        for (int i = 0; i < NUM_ACCUM; i++) begin
          r_acc_re[i] <= '0;
          r_acc_im[i] <= '0;
        end
        r_count    <= '0;
        r_sat_flag <= 1'b0;
        r_ovf      <= 1'b0;
      end else if (w_dump) begin
        for (int i = 0; i < NUM_ACCUM; i++) begin
          r_hold_re[i*ACC_W +: ACC_W] <= w_sum_re[i];
          r_hold_im[i*ACC_W +: ACC_W] <= w_sum_im[i];
          r_acc_re[i]                 <= '0;
          r_acc_im[i]                 <= '0;
        end
        r_dump_sat   <= r_sat_flag | w_clip_any;
        r_count      <= '0;
        r_sat_flag   <= 1'b0;
        r_dump_valid <= 1'b1;
        if (r_dump_valid && !bus.dump_ack) r_ovf <= 1'b1;
      end else if (w_accept) begin
        for (int i = 0; i < NUM_ACCUM; i++) begin
          r_acc_re[i] <= w_sum_re[i];
          r_acc_im[i] <= w_sum_im[i];
        end
        r_count    <= r_count + EPOCH_W'(1);
        r_sat_flag <= r_sat_flag | w_clip_any;
      end
    end
  end

  assign bus.dump_re    = r_hold_re;
  assign bus.dump_im    = r_hold_im;
  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_sat   = r_dump_sat;
  assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_corr_accum.sv
// Scoreboarded bench for corr_accum: an integer model predicts the outputs after every edge,
// a monitor compares them on the falling edge; directed epochs plus a random run.
module tb_corr_accum;
  localparam int NA   = 2;
  localparam int AW   = 8;
  localparam int EW   = 6;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));
  localparam int CMAX = (1 << EW) - 1;

  typedef struct {
    logic [NA*AW-1:0] re;
    logic [NA*AW-1:0] im;
    logic             valid;
    logic             sat;
    logic             ovf;
  } exp_t;

  logic pclk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  corr_accum_if #(.NUM_ACCUM(NA), .ACC_W(AW), .EPOCH_W(EW)) bus ();
  corr_accum #(.NUM_ACCUM(NA), .ACC_W(AW), .EPOCH_W(EW)) dut (
    .pclk (pclk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  // Reference model state, kept as plain integers.
  int   m_acc_re[NA], m_acc_im[NA], m_hold_re[NA], m_hold_im[NA];
  int   m_cnt;
  bit   m_flag, m_valid, m_sat, m_ovf;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [1:0] s, input logic code);
    int v;
    v = s[0] ? 3 : 1;
    if (s[1]) v = -v;
    if (code) v = -v;
    return v;
  endfunction

  function automatic int clampv(input int x, inout bit hit);
    if (x > AMAX) begin hit = 1; return AMAX; end
    if (x < AMIN) begin hit = 1; return AMIN; end
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_acc_re[i] = 0; m_acc_im[i] = 0; m_hold_re[i] = 0; m_hold_im[i] = 0;
    end
    m_cnt = 0; m_flag = 0; m_valid = 0; m_sat = 0; m_ovf = 0;
  endtask

  // Applies one clock edge's worth of rules to the model using the inputs the bench drove.
  task automatic model_edge();
    int   nre[NA], nim[NA];
    int   len;
    bit   hit, ack, last;
    exp_t e;
    ack = bus.dump_ack;
    if (!bus.enable) begin
      for (int i = 0; i < NA; i++) begin m_acc_re[i] = 0; m_acc_im[i] = 0; end
      m_cnt = 0; m_flag = 0; m_ovf = 0;
      if (ack) m_valid = 0;
    end else if (bus.sample_en) begin
      hit = 0;
      for (int i = 0; i < NA; i++) begin
        nre[i] = clampv(m_acc_re[i] + decode(bus.signal_re[2*i +: 2], bus.code_in), hit);
        nim[i] = clampv(m_acc_im[i] + decode(bus.signal_im[2*i +: 2], bus.code_in), hit);
      end
      len  = (bus.epoch_len == 0) ? 1 : int'(bus.epoch_len);
      last = (m_cnt == len - 1) || (m_cnt == CMAX);
      if (last) begin
        for (int i = 0; i < NA; i++) begin
          m_hold_re[i] = nre[i]; m_hold_im[i] = nim[i]; m_acc_re[i] = 0; m_acc_im[i] = 0;
        end
        m_sat = m_flag | hit;
        m_cnt = 0; m_flag = 0;
        if (m_valid && !ack) m_ovf = 1;
        m_valid = 1;
      end else begin
        for (int i = 0; i < NA; i++) begin m_acc_re[i] = nre[i]; m_acc_im[i] = nim[i]; end
        m_cnt++;
        m_flag = m_flag | hit;
        if (ack) m_valid = 0;
      end
    end else if (ack) begin
      m_valid = 0;
    end
    for (int i = 0; i < NA; i++) begin
      e.re[i*AW +: AW] = m_hold_re[i][AW-1:0];
      e.im[i*AW +: AW] = m_hold_im[i][AW-1:0];
    end
    e.valid = m_valid; e.sat = m_sat; e.ovf = m_ovf;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic en, input logic se, input logic [2*NA-1:0] re,
                      input logic [2*NA-1:0] im, input logic code, input logic [EW-1:0] len,
                      input logic ack);
    bus.enable = en; bus.sample_en = se; bus.signal_re = re; bus.signal_im = im;
    bus.code_in = code; bus.epoch_len = len; bus.dump_ack = ack;
    @(posedge pclk);
    #1;
    model_edge();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_re"},    32'(bus.dump_re), 0);
    check({tag, "_im"},    32'(bus.dump_im), 0);
    check({tag, "_valid"}, 32'(bus.dump_valid), 0);
    check({tag, "_sat"},   32'(bus.dump_sat), 0);
    check({tag, "_ovf"},   32'(bus.ovf), 0);
  endtask

  // Monitor: compares the DUT against the queued prediction once per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("mon_dump_re",    32'(bus.dump_re),    32'(e.re));
        check("mon_dump_im",    32'(bus.dump_im),    32'(e.im));
        check("mon_dump_valid", 32'(bus.dump_valid), 32'(e.valid));
        check("mon_dump_sat",   32'(bus.dump_sat),   32'(e.sat));
        check("mon_ovf",        32'(bus.ovf),        32'(e.ovf));
      end
    end
  end

  initial begin
    bus.enable = 0; bus.sample_en = 0; bus.signal_re = '0; bus.signal_im = '0;
    bus.code_in = 0; bus.epoch_len = '0; bus.dump_ack = 0;
    model_reset();
    repeat (3) @(negedge pclk);
    #1;
    check_zero_outputs("reset");
    reset = 0;

    // Lane0 re=+3 for 4 samples -> 12; lane1 re alternates +1/-1 -> 0.
    for (int k = 0; k < 4; k++) begin
      step(1, 1, {(k % 2) ? 2'b10 : 2'b00, 2'b01}, 4'b0000, 0, 6'd4, 0);
      if (k < 3) check("a_no_early_valid", 32'(bus.dump_valid), 0);
    end
    check("a_valid",    32'(bus.dump_valid), 1);
    check("a_lane0_re", 32'(bus.dump_re[7:0]), 32'd12);
    check("a_lane1_re", 32'(bus.dump_re[15:8]), 32'd0);
    step(1, 0, '0, '0, 0, 6'd4, 1);
    check("a_ack_clears", 32'(bus.dump_valid), 0);

    // Lane1 im=-1 wiped by code 1 -> +1, strobed every other cycle, epoch 3 -> +3.
    for (int k = 0; k < 6; k++) begin
      step(1, (k % 2) == 0, 4'b0000, 4'b1000, 1, 6'd3, 0);
      if (k < 4) check("b_no_early_valid", 32'(bus.dump_valid), 0);
      if (k == 4) check("b_lane1_im", 32'(bus.dump_im[15:8]), 32'd3);
    end
    step(1, 0, '0, '0, 0, 6'd3, 1);

    // Saturation both ways, then a clean epoch clears dump_sat.
    for (int k = 0; k < 50; k++) step(1, 1, 4'b0001, 4'b0000, 0, 6'd50, 0);
    check("c_pos_clamp", 32'(bus.dump_re[7:0]), 32'h7f);
    check("c_pos_sat",   32'(bus.dump_sat), 1);
    step(1, 0, '0, '0, 0, 6'd50, 1);
    for (int k = 0; k < 50; k++) step(1, 1, 4'b0011, 4'b0000, 0, 6'd50, 0);
    check("c_neg_clamp", 32'(bus.dump_re[7:0]), 32'h80);
    check("c_neg_sat",   32'(bus.dump_sat), 1);
    step(1, 0, '0, '0, 0, 6'd50, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 4'b0000, 4'b0000, 0, 6'd4, 0);
    check("c_clean_sat", 32'(bus.dump_sat), 0);
    step(1, 0, '0, '0, 0, 6'd4, 1);

    // Two unread epochs -> ovf; enable low clears it.
    for (int k = 0; k < 4; k++) step(1, 1, 4'b0000, 4'b0000, 0, 6'd2, 0);
    check("d_ovf_set",   32'(bus.ovf), 1);
    check("d_second_ep", 32'(bus.dump_re[7:0]), 32'd2);
    step(0, 0, '0, '0, 0, 6'd2, 0);
    check("d_ovf_clear", 32'(bus.ovf), 0);
    step(1, 0, '0, '0, 0, 6'd2, 1);

    // Ack on the dump edge keeps valid and does not flag ovf.
    for (int k = 0; k < 4; k++) step(1, 1, 4'b0000, 4'b0000, 0, 6'd2, k == 3);
    check("e_valid_held", 32'(bus.dump_valid), 1);
    check("e_no_ovf",     32'(bus.ovf), 0);
    step(1, 0, '0, '0, 0, 6'd2, 1);
    check("e_ack_clears", 32'(bus.dump_valid), 0);

    // Reset mid-epoch, then a full epoch of +1 must give 4.
    for (int k = 0; k < 2; k++) step(1, 1, 4'b0000, 4'b0000, 0, 6'd4, 0);
    @(negedge pclk);
    #1;
    bus.sample_en = 0;
    reset = 1;
    #1;
    check_zero_outputs("f_midreset");
    model_reset();
    @(negedge pclk);
    #1;
    reset = 0;
    for (int k = 0; k < 4; k++) step(1, 1, 4'b0000, 4'b0000, 0, 6'd4, 0);
    check("f_fresh_epoch", 32'(bus.dump_re[7:0]), 32'd4);
    step(1, 0, '0, '0, 0, 6'd4, 1);

    // epoch_len=0 behaves as 1: every accepted sample dumps.
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 4'b0001, 4'b0000, 0, 6'd0, 1);
      check("g_len0_valid", 32'(bus.dump_valid), 1);
      check("g_len0_re",    32'(bus.dump_re[7:0]), 32'd3);
      check("g_len0_ovf",   32'(bus.ovf), 0);
    end
    step(1, 0, '0, '0, 0, 6'd0, 1);

    // Lowering epoch_len below the count runs the counter to wrap: 64 samples total.
    for (int k = 0; k < 8; k++) step(1, 1, 4'b0000, 4'b0000, 0, 6'd10, 0);
    for (int k = 0; k < 56; k++) begin
      step(1, 1, 4'b0000, 4'b0000, 0, 6'd3, 0);
      if (k == 54) check("h_no_early_wrap", 32'(bus.dump_valid), 0);
    end
    check("h_wrap_valid", 32'(bus.dump_valid), 1);
    check("h_wrap_re",    32'(bus.dump_re[7:0]), 32'd64);
    step(1, 0, '0, '0, 0, 6'd3, 1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 16) != 0, ($urandom % 3) != 0, 4'($urandom), 4'($urandom),
           1'($urandom), 6'($urandom_range(0, 5)), ($urandom % 3) == 0);
    end

    repeat (2) @(negedge pclk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
